// File: rtl/reg16_pkg.sv
// Shared definitions for the 16-bit register bank and its serial read-out path.
// Holds the reader FSM encoding, the default data width and the bank reset value.
package reg16_pkg;

  localparam int          REG16_WIDTH    = 16;
  localparam logic [15:0] REG16_SNAP_RST = 16'h0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Beat counter width: must reach WIDTH (the parity beat index) without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/reg16_serial_reader_bit_counter.sv
// Beat counter for the serial reader: synchronous clear, count enable and a
// terminal-count flag raised while the count equals i_last.
module bit_counter #(
  parameter int CW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_last,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/reg16_serial_reader.sv
// Snapshots the register on START and streams it MSB first over a valid/ready link.
// Optional even-parity trailer beat when REG16_SERIAL_READER_PARITY_EN is defined.
module reg16_serial_reader
  import reg16_pkg::*;
#(
  parameter int               WIDTH    = REG16_WIDTH,
  parameter logic [WIDTH-1:0] SNAP_RST = WIDTH'(REG16_SNAP_RST)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        START,
  input  logic [WIDTH-1:0]            DIN,
  output logic                        SOUT,
  output logic                        SVALID,
  input  logic                        SREADY,
  output logic                        BUSY,
  output logic                        DONE,
  output state_t                      DBG_STATE,
  output logic [cnt_width(WIDTH)-1:0] DBG_COUNT,
  output logic [WIDTH-1:0]            DBG_SNAP
);

  localparam int CW = cnt_width(WIDTH);
`ifdef REG16_SERIAL_READER_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_snap;
  logic             r_sout;
  logic             r_svalid;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    w_count;
  logic             w_tc;
  logic             w_start;
  logic             w_xfer;
  logic             w_next_bit;

  // Handshake: a beat moves on a rising edge where SVALID and SREADY are both 1;
  // once SVALID rises in SHIFT, SOUT/SVALID hold until that beat moves.
  assign w_start = (r_state == IDLE) && START;
  assign w_xfer  = (r_state == SHIFT) && r_svalid && SREADY;

`ifdef REG16_SERIAL_READER_PARITY_EN
  logic r_parity;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_parity <= 1'b0;
    end else if (w_start) begin
      r_parity <= ^DIN;
    end
  end

  // After the last data bit the parity flag takes the SOUT slot.
  assign w_next_bit = (w_count == CW'(WIDTH - 1)) ? r_parity : r_snap[WIDTH-2];
`else
  assign w_next_bit = r_snap[WIDTH-2];
`endif

  bit_counter #(.CW(CW)) u_bit_counter (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_clr   (w_start),
    .i_en    (w_xfer),
    .i_last  (LAST),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_snap   <= SNAP_RST;
      r_sout   <= 1'b0;
      r_svalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sout   <= 1'b0;
          r_svalid <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          if (START) begin
            r_snap   <= DIN;
            r_sout   <= DIN[WIDTH-1];
            r_svalid <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_xfer) begin
            r_snap <= {r_snap[WIDTH-2:0], 1'b0};
            if (w_tc) begin
              r_sout   <= 1'b0;
              r_svalid <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= FIN;
            end else begin
              r_sout <= w_next_bit;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_sout   <= 1'b0;
          r_svalid <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign SOUT      = r_sout;
  assign SVALID    = r_svalid;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign DBG_STATE = r_state;
  assign DBG_COUNT = w_count;
  assign DBG_SNAP  = r_snap;

endmodule

// File: tb/tb_reg16_serial_reader.sv
// Bench for reg16_serial_reader: scenario tasks against a bit-queue reference model.
// Honours REG16_SERIAL_READER_PARITY_EN for the trailing parity beat.
module tb_reg16_serial_reader;
  import reg16_pkg::*;

  localparam int W = 16;
`ifdef REG16_SERIAL_READER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [W-1:0] DIN;
  logic         SOUT;
  logic         SVALID;
  logic         SREADY;
  logic         BUSY;
  logic         DONE;
  state_t       DBG_STATE;
  logic [4:0]   DBG_COUNT;
  logic [W-1:0] DBG_SNAP;

  reg16_serial_reader dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .DIN       (DIN),
    .SOUT      (SOUT),
    .SVALID    (SVALID),
    .SREADY    (SREADY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DBG_STATE (DBG_STATE),
    .DBG_COUNT (DBG_COUNT),
    .DBG_SNAP  (DBG_SNAP)
  );

  always #5 CLK = ~CLK;

  int         n_vec = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int         n_beats;
  int         done_at;
  int         last_x;
  int         stab_err;

  // Reference: data bits MSB first, then (optionally) the even parity of the word.
  function automatic void build_exp(input logic [W-1:0] w);
    exp_q.delete();
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
    if (PAR != 0) exp_q.push_back(^w);
  endfunction

  // Issue START for one edge (or keep it held), then scramble DIN.
  task automatic kick(input logic [W-1:0] w, input bit hold);
    START  = 1'b1;
    DIN    = w;
    SREADY = 1'($urandom_range(0, 1));
    @(negedge CLK);
    if (!hold) begin
      START = 1'b0;
      DIN   = W'($urandom);
    end
  endtask

  // Drive SREADY per pattern from cycle 1 and record accepted beats until DONE.
  // pat: 0 always ready, 1 ready pattern 1,0,0,1..., 2 random.
  // smode: 0 START low, 1 START+DIN=FFFF in cycles 2..10, 2 START held high.
  task automatic collect(input int pat, input int smode);
    logic prev_sv, prev_so, prev_rdy, rdy;
    got_q.delete();
    n_beats = 0; done_at = -1; last_x = -1; stab_err = 0;
    prev_sv = 1'b0; prev_so = 1'b0; prev_rdy = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (prev_sv && !prev_rdy && (SVALID !== 1'b1 || SOUT !== prev_so)) stab_err++;
      if (BUSY === 1'b1 && DONE !== 1'b1 && SVALID !== 1'b1) stab_err++;
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 1) || ((cyc % 4) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      SREADY = rdy;
      if (smode == 2) START = 1'b1;
      else if (smode == 1 && cyc >= 2 && cyc <= 10) begin
        START = 1'b1;
        DIN   = 16'hFFFF;
      end else START = 1'b0;
      if (SVALID === 1'b1 && rdy) begin
        got_q.push_back(SOUT);
        n_beats++;
        last_x = cyc;
      end
      if (DONE === 1'b1) begin
        done_at = cyc;
        @(negedge CLK);
        break;
      end
      prev_sv = SVALID; prev_so = SOUT; prev_rdy = rdy;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; START = 1'b0; SREADY = 1'b0; DIN = '0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if ({SOUT, SVALID, BUSY, DONE} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outputs got=%b want=0000", {SOUT, SVALID, BUSY, DONE});
    end
    n_vec++;
    if (DBG_STATE !== IDLE || DBG_COUNT !== 5'd0 || DBG_SNAP !== 16'h0100) begin
      n_err++; $display("FAIL reset_state got=%0d/%0d/%h want=0/0/0100", DBG_STATE, DBG_COUNT, DBG_SNAP);
    end
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    n_vec++;
    if (SVALID !== 1'b0 || BUSY !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset got sv=%b busy=%b want 0/0", SVALID, BUSY);
    end
    // Mid-stream asynchronous reset while bit 5 of A5C3 is presented.
    build_exp(16'hA5C3);
    kick(16'hA5C3, 1'b0);
    SREADY = 1'b1;
    repeat (5) @(negedge CLK);
    n_vec++;
    if (SVALID !== 1'b1 || SOUT !== exp_q[5]) begin
      n_err++; $display("FAIL bit5_before_reset got sv=%b sout=%b want 1/%b", SVALID, SOUT, exp_q[5]);
    end
    #1 RESET = 1'b0;
    #1;
    n_vec++;
    if ({SOUT, SVALID, BUSY, DONE} !== 4'b0000) begin
      n_err++; $display("FAIL async_reset got=%b want=0000", {SOUT, SVALID, BUSY, DONE});
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 20; i++) begin
      SREADY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      n_vec++;
      if (SVALID !== 1'b0 || BUSY !== 1'b0) begin
        n_err++; $display("FAIL quiet_after_reset cyc=%0d got sv=%b busy=%b want 0/0", i, SVALID, BUSY);
      end
    end
  endtask

  task automatic test_full_rate();
    logic [W-1:0] pk;
    build_exp(16'hA5C3);
    kick(16'hA5C3, 1'b0);
    collect(0, 0);
    n_vec++;
    if (n_beats != W + PAR) begin
      n_err++; $display("FAIL full_beats got=%0d want=%0d", n_beats, W + PAR);
    end
    pk = '0;
    for (int i = 0; i < W && i < got_q.size(); i++) pk = {pk[W-2:0], got_q[i]};
    n_vec++;
    if (pk !== 16'hA5C3) begin
      n_err++; $display("FAIL full_data got=%h want=a5c3", pk);
    end
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[0]) begin
        n_err++; $display("FAIL full_bit%0d got=%b want=%b", i, got_q[i], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_vec++;
    if (done_at != W + 1 + PAR) begin
      n_err++; $display("FAIL full_done_cycle got=%0d want=%0d", done_at, W + 1 + PAR);
    end
    n_vec++;
    if (DONE !== 1'b0 || BUSY !== 1'b0 || stab_err != 0) begin
      n_err++; $display("FAIL full_after_done got done=%b busy=%b stab=%0d want 0/0/0", DONE, BUSY, stab_err);
    end
  endtask

  task automatic test_backpressure();
    build_exp(16'h8001);
    kick(16'h8001, 1'b0);
    collect(1, 0);
    n_vec++;
    if (n_beats != W + PAR) begin
      n_err++; $display("FAIL bp_beats got=%0d want=%0d", n_beats, W + PAR);
    end
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[0]) begin
        n_err++; $display("FAIL bp_bit%0d got=%b want=%b", i, got_q[i], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_vec++;
    if (stab_err != 0) begin
      n_err++; $display("FAIL bp_stable got=%0d want=0", stab_err);
    end
    n_vec++;
    if (done_at < 0 || done_at != last_x + 1) begin
      n_err++; $display("FAIL bp_done_cycle got=%0d want=%0d", done_at, last_x + 1);
    end
  endtask

  task automatic test_ignored_start();
    int busy_cycles;
    build_exp(16'h0000);
    kick(16'h0000, 1'b0);
    collect(0, 1);
    n_vec++;
    if (n_beats != W + PAR) begin
      n_err++; $display("FAIL ign_beats got=%0d want=%0d", n_beats, W + PAR);
    end
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[0]) begin
        n_err++; $display("FAIL ign_bit%0d got=%b want=%b", i, got_q[i], exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    n_vec++;
    if (done_at != W + 1 + PAR) begin
      n_err++; $display("FAIL ign_done_cycle got=%0d want=%0d", done_at, W + 1 + PAR);
    end
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (SVALID !== 1'b0 || BUSY !== 1'b0) busy_cycles++;
      @(negedge CLK);
    end
    n_vec++;
    if (busy_cycles != 0) begin
      n_err++; $display("FAIL ign_no_restart got=%0d busy cycles want=0", busy_cycles);
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      build_exp(16'h0100);
      if (s == 0) kick(16'h0100, 1'b1);
      collect(0, 2);
      if (s == 1) START = 1'b0;
      for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[0]) begin
          n_err++; $display("FAIL b2b%0d_bit%0d got=%b want=%b", s, i, got_q[i], exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      n_vec++;
      if (n_beats != W + PAR || done_at != W + 1 + PAR) begin
        n_err++; $display("FAIL b2b%0d_timing got beats=%0d done=%0d want %0d/%0d", s, n_beats, done_at, W + PAR, W + 1 + PAR);
      end
      n_vec++;
      if (BUSY !== 1'b0 || SVALID !== 1'b0 || DBG_STATE !== IDLE) begin
        n_err++; $display("FAIL b2b%0d_idle_gap got busy=%b sv=%b st=%0d want 0/0/IDLE", s, BUSY, SVALID, DBG_STATE);
      end
      @(negedge CLK);
      if (s == 0) begin
        n_vec++;
        if (SVALID !== 1'b1 || BUSY !== 1'b1 || SOUT !== 1'b0) begin
          n_err++; $display("FAIL b2b_recapture got sv=%b busy=%b sout=%b want 1/1/0", SVALID, BUSY, SOUT);
        end
      end
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    for (int t = 0; t < 6; t++) begin
      w = W'($urandom);
      build_exp(w);
      kick(w, 1'b0);
      collect(2, 0);
      n_vec++;
      if (n_beats != W + PAR) begin
        n_err++; $display("FAIL rnd%0d_beats got=%0d want=%0d", t, n_beats, W + PAR);
      end
      for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[0]) begin
          n_err++; $display("FAIL rnd%0d_bit%0d word=%h got=%b want=%b", t, i, w, got_q[i], exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      n_vec++;
      if (stab_err != 0 || done_at < 0 || done_at != last_x + 1) begin
        n_err++; $display("FAIL rnd%0d_flow got stab=%0d done=%0d want 0/%0d", t, stab_err, done_at, last_x + 1);
      end
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
